beep_scheduler: RTL and testbench
=================================

Name: beep_scheduler

Overview:
Controller that sequences the board buzzer and shares it between two requesters. Requester 0 is the key path, driven from the debouncer's key_flag/key_value. Requester 1 is a generic alarm or status source. The block arbitrates requests, latches a beep pattern, plays it as timed on/gap segments, and drives the beep output. It replaces direct key-to-beep toggling in the top level.

Parameters:
- TICK_DIV, 50000, sys_clk cycles per ms tick (50 MHz gives 1 ms); must be >= 1.
- SHORT_MS, 100, on-time of a short beep in ms; 1..65535.
- LONG_MS, 500, on-time of a long beep in ms; 1..65535.
- GAP_MS, 100, off-time after every on segment in ms; 1..65535.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- key_flag  in  1  debounced key-valid strobe from the debouncer.
- key_value  in  1  debounced key level; 0 means pressed.
- alm_req  in  1  requester 1 level request; held until alm_ack.
- alm_pat  in  2  requester 1 pattern; sampled only in the grant cycle.
- alm_ack  out  1  one-cycle pulse when requester 1's request is taken.
- stop  in  1  synchronous abort of the pattern now playing.
- busy  out  1  high while a pattern is playing (state != IDLE).
- beep  out  1  buzzer drive, active-high.

Behaviour:
- Reset: beep=0, busy=0, alm_ack=0, key_pend=0, state=IDLE, all counters 0.
- Pattern codes (2 bits):
  - 0 = 1 x short
  - 1 = 2 x short
  - 2 = 1 x long
  - 3 = 3 x short
- Key request: a cycle with key_flag=1 and key_value=0 sets key_pend.
  - key_pend is a single flag; further presses while it is set are merged.
  - The key pattern is fixed at code 0.
- Arbitration: evaluated only in IDLE.
  - Fixed priority: key_pend beats alm_req.
  - A losing request stays pending; alm_req must be held by the source.
- Grant at rising edge k in IDLE:
  - Latch on_len and the remaining count from the granted pattern.
  - Go to ON; beep=1 and busy=1 from edge k onward.
  - If requester 1 was granted, alm_ack=1 for exactly the cycle after edge k. Otherwise clear key_pend at edge k.
  - A new key event arriving in the same cycle as the grant is kept pending.
- Timing: the ms prescaler and the ms counter are cleared on every segment entry.
  - ON lasts exactly on_len*TICK_DIV cycles.
  - GAP lasts exactly GAP_MS*TICK_DIV cycles.
- State machine:
  - IDLE -> ON on grant.
  - ON -> GAP when the ms count reaches on_len; decrement the remaining count at this point.
  - GAP -> ON when the ms count reaches GAP_MS and remaining != 0.
  - GAP -> IDLE when the ms count reaches GAP_MS and remaining == 0.
- Every pattern ends with a trailing gap. Total busy time = n*(on_len+GAP_MS)*TICK_DIV cycles, where n is the beep count.
- beep = 1 exactly when state == ON. beep is registered and has no glitches.
- stop=1 in ON or GAP: at the next edge go to IDLE with beep=0 and busy=0.
  - Pending requests are kept.
  - Arbitration can grant again on the edge after that.
  - stop in IDLE has no effect.
- Back-to-back: a request pending at the GAP->IDLE edge is granted on the following edge. This gives one IDLE cycle between patterns.
- Reset mid-pattern: everything returns to reset values immediately. Pending requests are lost.
- Widths:
  - Prescaler: $clog2(TICK_DIV) bits, at least 1.
  - ms counter: 16 bits.
  - Remaining count: 2 bits.
  - No wrap can occur within the legal parameter ranges.

Decomposition:
- Package beep_pkg:
  - Pattern code localparams PAT_1S, PAT_2S, PAT_1L, PAT_3S.
  - State encoding IDLE/ON/GAP.
  - A function mapping a pattern code to {count, is_long}.
- Sub-module ms_tick_gen:
  - Inputs: sys_clk, sys_rst, clr. Output: tick.
  - Parameter: TICK_DIV.
  - tick is a one-cycle pulse every TICK_DIV cycles after clr.
- The ms counter lives in beep_scheduler and counts ticks.

Test Plan:
(Bench parameters: TICK_DIV=10, SHORT_MS=3, LONG_MS=8, GAP_MS=2.)
- Key press (key_flag=1, key_value=0, one cycle) -> beep high 30 cycles, then low; busy high 50 cycles total.
- alm_req=1, alm_pat=3 -> alm_ack one pulse; three 30-cycle beeps with 20-cycle gaps; busy high 150 cycles.
- Key event and alm_req (pat=2) in the same IDLE cycle -> key pattern plays first. After 1 IDLE cycle, alm_ack is given and an 80-cycle beep follows.
- stop asserted 12 cycles into a pat=1 alarm -> beep=0 and busy=0 at the next edge. A key event pending during the alarm is granted on the edge after.
- key_flag with key_value=1 (release) -> no beep, busy stays 0. Two presses during an active pattern -> exactly one extra short beep afterwards.
- sys_rst pulsed mid-ON -> beep, busy and alm_ack go to 0 asynchronously. After release, the block stays IDLE with no pending key beep.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared definitions for the buzzer scheduler: pattern codes, FSM states
// and the pattern-code decoder.
package beep_pkg;

  localparam logic [1:0] PAT_1S = 2'd0;
  localparam logic [1:0] PAT_2S = 2'd1;
  localparam logic [1:0] PAT_1L = 2'd2;
  localparam logic [1:0] PAT_3S = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] count;
    logic       is_long;
  } pat_info_t;

  function automatic pat_info_t pat_decode(input logic [1:0] pat);
    pat_info_t info;
    case (pat)
      PAT_2S:  info = '{count: 2'd2, is_long: 1'b0};
      PAT_1L:  info = '{count: 2'd1, is_long: 1'b1};
      PAT_3S:  info = '{count: 2'd3, is_long: 1'b0};
      default: info = '{count: 2'd1, is_long: 1'b0};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/beep_scheduler_ms_tick_gen.sv
// Millisecond prescaler: tick_o pulses for one cycle every TICK_DIV cycles,
// counting from the most recent clr_i.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
    else                          cnt_d = cnt_q + PW'(1);
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  // Kept independent of clr_i so the segment-end logic upstream has no loop.
  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/beep_scheduler.sv
// Buzzer scheduler: arbitrates the key path and an alarm source, then plays
// the granted pattern as timed ON/GAP segments on a registered beep output.
module beep_scheduler
  import beep_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned SHORT_MS = 100,
  parameter int unsigned LONG_MS  = 500,
  parameter int unsigned GAP_MS   = 100
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       key_flag_i,
  input  logic       key_value_i,
  input  logic       alm_req_i,
  input  logic [1:0] alm_pat_i,
  output logic       alm_ack_o,
  input  logic       stop_i,
  output logic       busy_o,
  output logic       beep_o
);

  localparam logic [15:0] SHORT_LEN = 16'(SHORT_MS);
  localparam logic [15:0] LONG_LEN  = 16'(LONG_MS);
  localparam logic [15:0] GAP_LEN   = 16'(GAP_MS);

  state_t      state_q;
  logic        key_pend_q;
  logic [15:0] on_len_q;
  logic [1:0]  rem_q;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic        beep_q, busy_q, alm_ack_q;

  logic        key_evt, key_req, tick, seg_done, clr;
  pat_info_t   grant_info;
  logic [15:0] grant_len;

  assign key_evt = key_flag_i & ~key_value_i;
  assign key_req = key_pend_q | key_evt;

  always_comb begin
    grant_info = key_req ? pat_decode(PAT_1S) : pat_decode(alm_pat_i);
    grant_len  = grant_info.is_long ? LONG_LEN : SHORT_LEN;
  end

  always_comb begin
    seg_done = 1'b0;
    case (state_q)
      ST_ON:   seg_done = tick && (ms_cnt_q == on_len_q - 16'd1);
      ST_GAP:  seg_done = tick && (ms_cnt_q == GAP_LEN - 16'd1);
      default: seg_done = 1'b0;
    endcase
  end

  // Every segment boundary (and all of IDLE) restarts both time bases.
  assign clr = (state_q == ST_IDLE) | stop_i | seg_done;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .clr_i     (clr),
    .tick_o    (tick)
  );

  always_comb begin
    if (clr)       ms_cnt_d = '0;
    else if (tick) ms_cnt_d = ms_cnt_q + 16'd1;
    else           ms_cnt_d = ms_cnt_q;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) ms_cnt_q <= '0;
    else           ms_cnt_q <= ms_cnt_d;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q    <= ST_IDLE;
      key_pend_q <= 1'b0;
      on_len_q   <= '0;
      rem_q      <= '0;
      beep_q     <= 1'b0;
      busy_q     <= 1'b0;
      alm_ack_q  <= 1'b0;
    end else begin
      alm_ack_q <= 1'b0;
      if (key_evt) key_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (key_req || alm_req_i) begin
            state_q  <= ST_ON;
            beep_q   <= 1'b1;
            busy_q   <= 1'b1;
            on_len_q <= grant_len;
            rem_q    <= grant_info.count;
            // A fresh press that is itself granted is consumed; one arriving
            // while an older press is being granted stays pending.
            if (key_req) key_pend_q <= key_pend_q & key_evt;
            else         alm_ack_q  <= 1'b1;
          end
        end
        ST_ON: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            beep_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (seg_done) begin
            state_q <= ST_GAP;
            beep_q  <= 1'b0;
            rem_q   <= rem_q - 2'd1;
          end
        end
        ST_GAP: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (seg_done) begin
            if (rem_q != 2'd0) begin
              state_q <= ST_ON;
              beep_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          beep_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign beep_o    = beep_q;
  assign busy_o    = busy_q;
  assign alm_ack_o = alm_ack_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// Directed bench for beep_scheduler with a 10-cycle ms tick: on/gap/busy run
// lengths are collected by a monitor and scored against expected queues.
module tb_beep_scheduler;

  localparam int SHORT_CYC = 30;
  localparam int LONG_CYC  = 80;
  localparam int GAP_CYC   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_flag = 1'b0;
  logic       key_value = 1'b1;
  logic       alm_req = 1'b0;
  logic [1:0] alm_pat = 2'd0;
  logic       stop = 1'b0;
  logic       alm_ack, busy, beep;

  int checks = 0;
  int errors = 0;

  // Monitor-owned run records and test-owned expectations.
  logic [15:0] on_q[$], gap_q[$], busy_q[$];
  logic [15:0] exp_on_q[$], exp_gap_q[$], exp_busy_q[$];
  int rd_on = 0, rd_gap = 0, rd_busy = 0;
  int on_run = 0, gap_run = 0, busy_run = 0, ack_cnt = 0;

  always #5 clk = ~clk;

  beep_scheduler #(
    .TICK_DIV (10),
    .SHORT_MS (3),
    .LONG_MS  (8),
    .GAP_MS   (2)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .key_flag_i  (key_flag),
    .key_value_i (key_value),
    .alm_req_i   (alm_req),
    .alm_pat_i   (alm_pat),
    .alm_ack_o   (alm_ack),
    .stop_i      (stop),
    .busy_o      (busy),
    .beep_o      (beep)
  );

  always @(negedge clk) begin
    if (rst) begin
      on_run = 0;
      gap_run = 0;
      busy_run = 0;
    end else begin
      if (beep) on_run++;
      else if (on_run > 0) begin on_q.push_back(16'(on_run)); on_run = 0; end
      if (busy && !beep) gap_run++;
      else if (gap_run > 0) begin gap_q.push_back(16'(gap_run)); gap_run = 0; end
      if (busy) busy_run++;
      else if (busy_run > 0) begin busy_q.push_back(16'(busy_run)); busy_run = 0; end
      if (alm_ack) ack_cnt++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic press_key(input logic val);
    key_flag = 1'b1;
    key_value = val;
    step();
    key_flag = 1'b0;
    key_value = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (alm_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int idle;
    idle = 0;
    for (int i = 0; i < budget && idle < 3; i++) begin
      @(negedge clk);
      if (!busy && !alm_req) idle++;
      else idle = 0;
    end
    check({tag, "_done"}, idle, 3);
    step();
  endtask

  task automatic exp_seg(input int on_len, input int gap_len);
    exp_on_q.push_back(16'(on_len));
    if (gap_len > 0) exp_gap_q.push_back(16'(gap_len));
  endtask

  task automatic score(input string tag);
    check({tag, "_n_on"}, on_q.size(), exp_on_q.size());
    check({tag, "_n_gap"}, gap_q.size(), exp_gap_q.size());
    check({tag, "_n_busy"}, busy_q.size(), exp_busy_q.size());
    for (int i = rd_on; i < exp_on_q.size(); i++)
      check({tag, "_on_len"}, (i < on_q.size()) ? int'(on_q[i]) : -1, int'(exp_on_q[i]));
    for (int i = rd_gap; i < exp_gap_q.size(); i++)
      check({tag, "_gap_len"}, (i < gap_q.size()) ? int'(gap_q[i]) : -1, int'(exp_gap_q[i]));
    for (int i = rd_busy; i < exp_busy_q.size(); i++)
      check({tag, "_busy_len"}, (i < busy_q.size()) ? int'(busy_q[i]) : -1, int'(exp_busy_q[i]));
    rd_on = exp_on_q.size();
    rd_gap = exp_gap_q.size();
    rd_busy = exp_busy_q.size();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bc;

    // Reset
    #2 rst = 1'b1;
    #1;
    check("rst_beep", beep, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", alm_ack, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    steps(3);
    check("post_rst_busy", busy, 0);

    // Single key press: one short beep
    press_key(1'b0);
    @(negedge clk);
    check("s1_beep_on", beep, 1);
    check("s1_busy_on", busy, 1);
    wait_done("s1", 200);
    exp_seg(SHORT_CYC, GAP_CYC);
    exp_busy_q.push_back(16'(SHORT_CYC + GAP_CYC));
    score("s1");
    check("s1_ack_cnt", ack_cnt, 0);

    // Alarm pattern 3: three short beeps
    alm_pat = 2'd3;
    alm_req = 1'b1;
    wait_ack(10, lat);
    check("s2_ack_lat", lat, 2);
    alm_req = 1'b0;
    check("s2_beep_at_ack", beep, 1);
    @(negedge clk);
    check("s2_ack_pulse", alm_ack, 0);
    step();
    wait_done("s2", 400);
    repeat (3) exp_seg(SHORT_CYC, GAP_CYC);
    exp_busy_q.push_back(16'(3 * (SHORT_CYC + GAP_CYC)));
    score("s2");
    check("s2_ack_cnt", ack_cnt, 1);

    // Key and alarm pattern 2 together: key first, one idle cycle, then long beep
    key_flag = 1'b1;
    key_value = 1'b0;
    alm_pat = 2'd2;
    alm_req = 1'b1;
    step();
    key_flag = 1'b0;
    key_value = 1'b1;
    wait_ack(200, lat);
    check("s3_ack_lat", lat, 52);
    alm_req = 1'b0;
    step();
    wait_done("s3", 300);
    exp_seg(SHORT_CYC, GAP_CYC);
    exp_seg(LONG_CYC, GAP_CYC);
    exp_busy_q.push_back(16'(SHORT_CYC + GAP_CYC));
    exp_busy_q.push_back(16'(LONG_CYC + GAP_CYC));
    score("s3");
    check("s3_ack_cnt", ack_cnt, 2);

    // Stop 12 cycles into an alarm with a key pending
    alm_pat = 2'd1;
    alm_req = 1'b1;
    wait_ack(10, lat);
    check("s4_ack_lat", lat, 2);
    alm_req = 1'b0;
    step();
    press_key(1'b0);
    steps(9);
    stop = 1'b1;
    @(negedge clk);
    check("s4_beep_before_stop", beep, 1);
    step();
    stop = 1'b0;
    @(negedge clk);
    check("s4_beep_stopped", beep, 0);
    check("s4_busy_stopped", busy, 0);
    step();
    @(negedge clk);
    check("s4_key_regrant", busy, 1);
    step();
    wait_done("s4", 200);
    exp_seg(12, 0);
    exp_seg(SHORT_CYC, GAP_CYC);
    exp_busy_q.push_back(16'd12);
    exp_busy_q.push_back(16'(SHORT_CYC + GAP_CYC));
    score("s4");
    check("s4_ack_cnt", ack_cnt, 3);

    // Key release is ignored; two presses mid-pattern merge into one beep
    press_key(1'b1);
    steps(5);
    check("s5_release_busy", busy, 0);
    press_key(1'b0);
    steps(5);
    press_key(1'b0);
    steps(5);
    press_key(1'b0);
    wait_done("s5", 300);
    repeat (2) exp_seg(SHORT_CYC, GAP_CYC);
    repeat (2) exp_busy_q.push_back(16'(SHORT_CYC + GAP_CYC));
    score("s5");

    // Async reset during the ack cycle
    alm_pat = 2'd0;
    alm_req = 1'b1;
    wait_ack(10, lat);
    check("s6_ack_lat", lat, 2);
    #1 rst = 1'b1;
    alm_req = 1'b0;
    #1;
    check("s6_rst_ack", alm_ack, 0);
    check("s6_rst_beep", beep, 0);
    check("s6_rst_busy", busy, 0);
    steps(2);
    rst = 1'b0;
    steps(2);

    // Async reset mid-ON drops a pending key
    press_key(1'b0);
    steps(5);
    press_key(1'b0);
    steps(5);
    rst = 1'b1;
    #1;
    check("s7_rst_beep", beep, 0);
    check("s7_rst_busy", busy, 0);
    steps(3);
    rst = 1'b0;
    bc = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check("s7_no_pending_beep", bc, 0);
    score("s7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
